alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_mul_seq.sv | 55 +++++
 rtl/alu_pipe.sv | 152 +++++++++++++++
 tb/tb_alu_pipe.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and defaults for the pipelined ALU with an iterative multiplier.
package alu_pkg;

    localparam int DEF_W       = 8;
    localparam int DEF_CMP_LSB = 3;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_XOR   = 4'd2,
        OP_PAR   = 4'd3,
        OP_CMPHI = 4'd4,
        OP_SHL   = 4'd5,
        OP_SHR   = 4'd6,
        OP_PASS  = 4'd7,
        OP_MUL   = 4'd8
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one multiplier bit per cycle, W cycles after start.
// done marks the final iteration cycle; product already includes that last step.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] product
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(W);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          active_r;
    logic [CW-1:0] cnt_r;
    logic [W-1:0]  acc_r;
    logic [W-1:0]  mcand_r;
    logic [W-1:0]  mplier_r;
    logic [W-1:0]  step_acc_s;

    assign step_acc_s = acc_r + (mplier_r[0] ? mcand_r : {W{1'b0}});
    assign done       = active_r && (cnt_r == CNT_ONE);
    assign product    = step_acc_s;

    // Operand capture on start, then one partial product per cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            active_r <= 1'b0;
            cnt_r    <= {CW{1'b0}};
            acc_r    <= {W{1'b0}};
            mcand_r  <= {W{1'b0}};
            mplier_r <= {W{1'b0}};
        end else if (start) begin
            active_r <= 1'b1;
            cnt_r    <= CNT_INIT;
            acc_r    <= {W{1'b0}};
            mcand_r  <= a;
            mplier_r <= b;
        end else if (active_r) begin
            acc_r    <= step_acc_s;
            mcand_r  <= {mcand_r[W-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[W-1:1]};
            cnt_r    <= cnt_r - CNT_ONE;
            active_r <= (cnt_r != CNT_ONE);
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Single-stage ALU with valid/ready handshake; MUL runs iteratively and
// blocks new requests while in progress.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int CMP_LSB = DEF_CMP_LSB
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   in_op,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result,
    output logic         out_zero,
    output logic         out_eq,
    output logic         out_carry,
    output logic         busy
);

    localparam logic [W-1:0] SHIFT_LIM = W[W-1:0];

    state_t       state_r;
    state_t       state_n;
    logic         accept_s;
    logic         alu_load_s;
    logic         mul_start_s;
    logic         mul_done_s;
    logic         mul_load_s;
    logic         mul_eq_r;
    logic [W-1:0] mul_product_s;
    logic [W-1:0] alu_res_s;
    logic         alu_carry_s;
    logic [W:0]   wide_s;

    assign busy        = (state_r == ST_MUL);
    assign in_ready    = !reset && !busy && (!out_valid || out_ready);
    assign accept_s    = in_valid && in_ready;
    assign mul_start_s = accept_s && (in_op == OP_MUL);
    assign alu_load_s  = accept_s && (in_op != OP_MUL);
    assign mul_load_s  = (state_r == ST_MUL) && mul_done_s;

    alu_mul_seq #(.W(W)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start_s),
        .a       (in_a),
        .b       (in_b),
        .done    (mul_done_s),
        .product (mul_product_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // FSM next state; DONE is the one-cycle "result just delivered" state
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mul_start_s) state_n = ST_MUL;
                else             state_n = ST_IDLE;
            end
            ST_MUL: begin
                if (mul_done_s) state_n = ST_DONE;
                else            state_n = ST_MUL;
            end
            ST_DONE: begin
                if (mul_start_s) state_n = ST_MUL;
                else             state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Single-cycle operations feeding the output register
    always_comb begin
        alu_res_s   = in_a;
        alu_carry_s = 1'b0;
        wide_s      = {(W+1){1'b0}};
        case (in_op)
            OP_ADD: begin
                wide_s      = {1'b0, in_a} + {1'b0, in_b};
                alu_res_s   = wide_s[W-1:0];
                alu_carry_s = wide_s[W];
            end
            OP_SUB: begin
                wide_s      = {1'b0, in_a} - {1'b0, in_b};
                alu_res_s   = wide_s[W-1:0];
                alu_carry_s = wide_s[W];
            end
            OP_XOR:   alu_res_s = in_a ^ in_b;
            OP_PAR:   alu_res_s = {{(W-1){1'b0}}, ^in_a};
            OP_CMPHI: alu_res_s = {{(W-1){1'b0}}, (in_a[W-1:CMP_LSB] == in_b[W-1:CMP_LSB])};
            OP_SHL: begin
                if (in_b >= SHIFT_LIM) alu_res_s = {W{1'b0}};
                else                   alu_res_s = in_a << in_b;
            end
            OP_SHR: begin
                if (in_b >= SHIFT_LIM) alu_res_s = {W{1'b0}};
                else                   alu_res_s = in_a >> in_b;
            end
            OP_PASS: alu_res_s = in_a;
            default: alu_res_s = in_a;
        endcase
    end

    // Equality of MUL operands is captured at accept, alongside the operands
    always_ff @(posedge clk) begin
        if (reset) begin
            mul_eq_r <= 1'b0;
        end else if (mul_start_s) begin
            mul_eq_r <= (in_a == in_b);
        end
    end

    // Output register: new result wins, otherwise hold until consumed
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_result <= {W{1'b0}};
            out_zero   <= 1'b0;
            out_eq     <= 1'b0;
            out_carry  <= 1'b0;
        end else if (alu_load_s) begin
            out_valid  <= 1'b1;
            out_result <= alu_res_s;
            out_zero   <= (alu_res_s == {W{1'b0}});
            out_eq     <= (in_a == in_b);
            out_carry  <= alu_carry_s;
        end else if (mul_load_s) begin
            out_valid  <= 1'b1;
            out_result <= mul_product_s;
            out_zero   <= (mul_product_s == {W{1'b0}});
            out_eq     <= mul_eq_r;
            out_carry  <= 1'b0;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: W=8 instance with directed + random traffic,
// plus a W=16/CMP_LSB=4 instance with a short directed sequence.
module tb_alu_pipe;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, in_valid, in_ready, out_valid, out_ready;
    logic         out_zero, out_eq, out_carry, busy;
    logic [3:0]   in_op;
    logic [W-1:0] in_a, in_b, out_result;

    logic         reset16, in_valid16, in_ready16, out_valid16, out_ready16;
    logic         out_zero16, out_eq16, out_carry16, busy16;
    logic [3:0]   in_op16;
    logic [15:0]  in_a16, in_b16, out_result16;

    alu_pipe #(.W(8), .CMP_LSB(3)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero),
        .out_eq(out_eq), .out_carry(out_carry), .busy(busy)
    );

    alu_pipe #(.W(16), .CMP_LSB(4)) dut16 (
        .clk(clk), .reset(reset16), .in_valid(in_valid16), .in_ready(in_ready16),
        .in_op(in_op16), .in_a(in_a16), .in_b(in_b16), .out_valid(out_valid16),
        .out_ready(out_ready16), .out_result(out_result16), .out_zero(out_zero16),
        .out_eq(out_eq16), .out_carry(out_carry16), .busy(busy16)
    );

    typedef struct {
        logic [7:0] res;
        logic       zero;
        logic       eq;
        logic       carry;
        int         due;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   front_seen = 1'b0;
    bit   rand_mode = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model straight from the opcode definitions, using integer arithmetic
    function automatic exp_t model(input int op, input int a, input int b, input int c);
        exp_t e;
        int   r;
        e.carry = 1'b0;
        case (op)
            0: begin r = a + b; e.carry = (r > 255); end
            1: begin r = a - b; e.carry = (a < b); end
            2: r = a ^ b;
            3: r = $countones(a) % 2;
            4: r = ((a >> 3) == (b >> 3)) ? 1 : 0;
            5: r = (b >= 8) ? 0 : (a << b);
            6: r = (b >= 8) ? 0 : (a >> b);
            8: r = a * b;
            default: r = a;
        endcase
        r      = r & 255;
        e.res  = r[7:0];
        e.zero = (r == 0);
        e.eq   = (a == b);
        e.due  = c + 1 + ((op == 8) ? W : 0);
        return e;
    endfunction

    // Stimulus side of the scoreboard: record every accepted request
    initial forever begin
        @(posedge clk);
        if (reset) exp_q.delete();
        else if (in_valid && in_ready)
            exp_q.push_back(model(int'(in_op), int'(in_a), int'(in_b), cyc));
        cyc++;
    end

    // Monitor: compare whatever the DUT presents against the queue head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                front_seen = 1'b0;
            end else if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q[0];
                    chk("result", {24'd0, out_result}, {24'd0, e.res});
                    chk("zero", {31'd0, out_zero}, {31'd0, e.zero});
                    chk("eq", {31'd0, out_eq}, {31'd0, e.eq});
                    chk("carry", {31'd0, out_carry}, {31'd0, e.carry});
                    if (!front_seen) begin
                        chk("latency", cyc, e.due);
                        front_seen = 1'b1;
                    end
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        front_seen = 1'b0;
                    end
                end
            end
        end
    end

    task automatic issue(input int op, input int a, input int b);
        int n;
        bit acc;
        in_valid = 1'b1;
        in_op    = op[3:0];
        in_a     = a[7:0];
        in_b     = b[7:0];
        n = 0;
        acc = 1'b0;
        while (!acc && n < 100) begin
            @(posedge clk);
            n++;
            if (in_ready) acc = 1'b1;
            else begin
                #1;
                if (rand_mode) out_ready = ($urandom_range(0, 2) != 0);
            end
        end
        chk("issue_accept", {31'd0, acc}, 32'd1);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, nb, first, op, a, b;
        logic [7:0]  snap;
        logic [15:0] res16;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_op = 4'd0; in_a = 8'd0; in_b = 8'd0;
        reset16 = 1'b1; in_valid16 = 1'b0; out_ready16 = 1'b1;
        in_op16 = 4'd0; in_a16 = 16'd0; in_b16 = 16'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_result", {24'd0, out_result}, 32'd0);
        chk("rst_flags", {29'd0, out_zero, out_eq, out_carry}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Arithmetic corner cases
        issue(0, 8'hF0, 8'h20);
        issue(1, 8'h05, 8'h05);
        issue(1, 8'h03, 8'h05);
        issue(5, 8'h01, 9);
        issue(6, 8'h80, 8);

        // Back-to-back stream must be one accept per cycle
        t0 = cyc;
        issue(2, 8'h3C, 8'h0F);
        issue(3, 8'h07, 8'h00);
        issue(4, 8'h2A, 8'h2F);
        issue(2, 8'h5A, 8'h5A);
        issue(3, 8'h80, 8'h01);
        issue(4, 8'h2A, 8'h22);
        chk("stream_throughput", cyc - t0, 32'd6);

        // Output stall: result frozen and no accept
        issue(2, 8'h55, 8'hAA);
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 4'd0; in_a = 8'h11; in_b = 8'h22;
        @(negedge clk);
        snap = out_result;
        repeat (3) begin
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_frozen", {24'd0, out_result}, {24'd0, snap});
            @(negedge clk);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;

        // MUL timing: busy exactly W cycles, no accept while busy
        issue(8, 13, 11);
        in_valid = 1'b1; in_op = 4'd7; in_a = 8'h99; in_b = 8'h00;
        nb = 0;
        for (int k = 1; k <= W + 3; k++) begin
            @(negedge clk);
            if (busy) begin
                nb++;
                chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
            end
            if (k == 1) in_a = 8'h42;
        end
        chk("mul_busy_cycles", nb, W);
        @(posedge clk); #1;
        in_valid = 1'b0;
        issue(8, 8'hFF, 8'hFF);
        issue(7, 8'hC3, 8'h00);

        // Reset in the middle of a multiply aborts it
        issue(8, 8'h77, 8'h05);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (W + 4) @(posedge clk);
        #1;
        issue(0, 1, 1);

        // Randomized traffic with random back-pressure
        rand_mode = 1'b1;
        for (int i = 0; i < 150; i++) begin
            op = $urandom_range(0, 15);
            a  = $urandom_range(0, 255);
            b  = $urandom_range(0, 255);
            if (op == 5 || op == 6) b = $urandom_range(0, 12);
            if (op == 4 && $urandom_range(0, 1) == 1) b = a ^ $urandom_range(0, 7);
            if ($urandom_range(0, 7) == 0) b = a;
            out_ready = ($urandom_range(0, 3) != 0);
            issue(op, a, b);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk); #1;
            end
        end
        rand_mode = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", exp_q.size(), 32'd0);

        // Wide instance: wrap-around add and MUL latency
        @(posedge clk); #1;
        reset16 = 1'b0;
        in_valid16 = 1'b1; in_op16 = 4'd0; in_a16 = 16'hFFFF; in_b16 = 16'h0001;
        @(posedge clk);
        chk("w16_add_accept", {31'd0, in_ready16}, 32'd1);
        #1 in_valid16 = 1'b0;
        @(negedge clk);
        chk("w16_add_valid", {31'd0, out_valid16}, 32'd1);
        chk("w16_add_result", {16'd0, out_result16}, 32'd0);
        chk("w16_add_flags", {29'd0, out_zero16, out_eq16, out_carry16}, 32'b101);
        @(posedge clk); #1;
        in_valid16 = 1'b1; in_op16 = 4'd8; in_a16 = 16'h0100; in_b16 = 16'h0100;
        @(posedge clk);
        chk("w16_mul_accept", {31'd0, in_ready16}, 32'd1);
        #1 in_valid16 = 1'b0;
        nb = 0; first = 0; res16 = 16'hDEAD;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (busy16) nb++;
            if (out_valid16 && first == 0) begin
                first = k;
                res16 = out_result16;
                chk("w16_mul_flags", {29'd0, out_zero16, out_eq16, out_carry16}, 32'b110);
            end
        end
        chk("w16_mul_busy", nb, 32'd16);
        chk("w16_mul_latency", first, 32'd17);
        chk("w16_mul_result", {16'd0, res16}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
